// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types and helpers for the memory-stage access engine:
//   - size_e  : access size encodings (byte / half / word)
//   - state_e : access FSM states (IDLE / ACCESS / DONE)
//   - norm_size    : folds the reserved size code onto word
//   - lane_enable  : little-endian byte-lane enables for a size/lane pair
//   - lane_wdata   : store data replicated onto the byte lanes
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // The reserved code 2'b11 behaves exactly like a word access.
    function automatic size_e norm_size(input logic [1:0] s);
        case (s)
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input size_e s, input logic [1:0] lane);
        case (s)
            SIZE_BYTE: return 4'b0001 << lane;
            SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicating the narrow datum onto every lane lets the enables alone
    // select which bytes the memory actually writes.
    function automatic logic [31:0] lane_wdata(input size_e s, input logic [31:0] wd);
        case (s)
            SIZE_BYTE: return {4{wd[7:0]}};
            SIZE_HALF: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-bus handshake between the memory-stage access engine (master) and the
// data memory (slave).
//   bus_req_o      request, held until acknowledged
//   bus_we_o       1 = write
//   bus_addr_o     word-aligned byte address
//   bus_byte_en_o  byte-lane enables
//   bus_wdata_o    lane-replicated store data
//   bus_ack_i      one-cycle acknowledge
//   bus_rdata_i    read word, valid with bus_ack_i
// -----------------------------------------------------------------------------
interface mem_access_unit_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_byte_en_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_byte_en_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_byte_en_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );

endinterface

// File: rtl/mem_access_unit_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational lane select plus sign/zero extension of a read word.
//   rdata_i     raw 32-bit read word
//   lane_i      byte address bits [1:0] of the load
//   size_i      access size
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   data_o      right-justified, extended result
// -----------------------------------------------------------------------------
module load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rdata_i[{lane_i, 3'b000} +: 8];
        half_s = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_BYTE: data_o = unsigned_i ? {24'h0, byte_s} : 32'(byte_s);
            SIZE_HALF: data_o = unsigned_i ? {16'h0, half_s} : 32'(half_s);
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage access engine. Converts EX/MEM load/store control into a
// handshaked data-bus transaction, stalls the pipeline until the bus answers
// (or times out), and presents the extended load result to MEM/WB.
//   clk, reset         clock, asynchronous active-low reset
//   mem_read_i/_write_i load / store request (write wins when both set)
//   mem_size_i         00 byte, 01 half, 10/11 word
//   mem_unsigned_i     zero-extend loads when set
//   address_i          byte address
//   write_data_i       right-justified store data
//   bus                data-bus master port
//   stall_o            freezes the upstream pipeline
//   read_data_mmry_o   extended load data, held until next DONE/fault
//   misaligned_o       alignment / range fault, one cycle
//   bus_error_o        timeout indication, DONE cycle only
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MEMORY_DEPTH   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [31:0]       address_i,
    input  logic [31:0]       write_data_i,
    mem_access_unit_if.master bus,
    output logic              stall_o,
    output logic [31:0]       read_data_mmry_o,
    output logic              misaligned_o,
    output logic              bus_error_o
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ADDR_LIMIT = 32'(MEMORY_DEPTH * 4);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q, rd_q, ext_data;
    logic [3:0]       be_q;
    logic [1:0]       lane_q;
    size_e            size_q, size_n;
    logic             we_q, uns_q, err_q;
    logic             req, fault, start, fault_hit, timeout;

    assign req     = mem_read_i | mem_write_i;
    assign size_n  = norm_size(mem_size_i);
    assign fault   = (size_n == SIZE_HALF && address_i[0])
                   || (size_n == SIZE_WORD && address_i[1:0] != 2'b00)
                   || (address_i >= ADDR_LIMIT);
    // Gating with reset keeps every output at 0 while reset is held, even if
    // the upstream stage is still presenting a request.
    assign start     = reset && (state_q == IDLE) && req && !fault;
    assign fault_hit = reset && (state_q == IDLE) && req && fault;
    // Counter value CNT_LAST marks the final permitted ACCESS cycle.
    assign timeout   = (cnt_q == CNT_LAST);
    assign cnt_d     = (state_q == ACCESS) ? cnt_q + CNT_W'(1) : '0;

    load_extender u_ext (
        .rdata_i    (bus.bus_rdata_i),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCESS;
            // Ack is tested first so an ack on the last permitted cycle wins.
            ACCESS:  if (bus.bus_ack_i || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o          = start || (state_q == ACCESS);
        misaligned_o     = fault_hit;
        read_data_mmry_o = fault_hit ? 32'h0 : rd_q;
        bus_error_o      = err_q;
    end

    assign bus.bus_req_o     = (state_q == ACCESS);
    assign bus.bus_we_o      = we_q;
    assign bus.bus_addr_o    = addr_q;
    assign bus.bus_byte_en_o = be_q;
    assign bus.bus_wdata_o   = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lane_q  <= '0;
            size_q  <= SIZE_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= (state_q == ACCESS) && !bus.bus_ack_i && timeout;
            if (start) begin
                addr_q  <= {address_i[31:2], 2'b00};
                wdata_q <= lane_wdata(size_n, write_data_i);
                be_q    <= lane_enable(size_n, address_i[1:0]);
                lane_q  <= address_i[1:0];
                size_q  <= size_n;
                we_q    <= mem_write_i;
                uns_q   <= mem_unsigned_i;
            end
            if (state_q == ACCESS && bus.bus_ack_i) rd_q <= ext_data;
            else if (state_q == ACCESS && timeout)  rd_q <= '0;
            else if (fault_hit)                     rd_q <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_i, mem_write_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [31:0] address_i, write_data_i;
    logic        stall_o, misaligned_o, bus_error_o;
    logic [31:0] read_data_mmry_o;

    int checks = 0;
    int passed = 0;

    // observations recorded by the access driver
    int          o_stall, o_req;
    logic        o_mis, o_mis_after, o_req_fault, o_req_after, o_we;
    logic        o_done_stall, o_done_req, o_err, o_err_after, o_stall_after;
    logic [31:0] o_fault_rd, o_addr0, o_addr_last, o_wd, o_data, o_data_after;
    logic [3:0]  o_be;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT_CYCLES(4), .MEMORY_DEPTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_i       (mem_read_i),
        .mem_write_i      (mem_write_i),
        .mem_size_i       (mem_size_i),
        .mem_unsigned_i   (mem_unsigned_i),
        .address_i        (address_i),
        .write_data_i     (write_data_i),
        .bus              (bus_if),
        .stall_o          (stall_o),
        .read_data_mmry_o (read_data_mmry_o),
        .misaligned_o     (misaligned_o),
        .bus_error_o      (bus_error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read_i = 0; mem_write_i = 0; mem_size_i = 2'b00; mem_unsigned_i = 0;
        address_i = 32'h0; write_data_i = 32'h0;
    endtask

    // Drives one instruction starting in IDLE (at posedge+1) and records what
    // the DUT does. ack_k < 0 means the bus never acknowledges.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_k,
                          input logic [31:0] rdat);
        int cyc;
        o_stall = 0; o_req = 0;
        mem_read_i = rd; mem_write_i = wr; mem_size_i = sz; mem_unsigned_i = uns;
        address_i = a; write_data_i = wd;
        #1;
        o_mis = misaligned_o; o_fault_rd = read_data_mmry_o; o_req_fault = bus_if.bus_req_o;
        if (stall_o) o_stall++;
        if (!stall_o) begin
            tick();
            clear_inputs();
            #1;
            o_mis_after = misaligned_o; o_data_after = read_data_mmry_o; o_req_after = bus_if.bus_req_o;
            tick();
            return;
        end
        tick();
        cyc = 0;
        while (bus_if.bus_req_o === 1'b1 && cyc < 40) begin
            o_req++;
            if (cyc == 0) begin
                o_addr0 = bus_if.bus_addr_o; o_be = bus_if.bus_byte_en_o;
                o_wd = bus_if.bus_wdata_o; o_we = bus_if.bus_we_o;
                // upstream inputs wander while the pipeline is frozen
                address_i = a ^ 32'h0000_0044; write_data_i = ~wd;
                mem_size_i = ~sz; mem_unsigned_i = ~uns;
            end
            if (cyc == ack_k) begin
                bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = rdat;
            end
            #1;
            if (stall_o) o_stall++;
            o_addr_last = bus_if.bus_addr_o;
            tick();
            bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = 32'h5A5A_0F0F;
            cyc++;
        end
        clear_inputs();
        #1;
        o_done_stall = stall_o; o_done_req = bus_if.bus_req_o;
        o_data = read_data_mmry_o; o_err = bus_error_o;
        tick();
        #1;
        o_err_after = bus_error_o; o_data_after = read_data_mmry_o; o_stall_after = stall_o;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_if.bus_req_o !== 1'b0) $display("FAIL rst_req got %b exp 0", bus_if.bus_req_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall_o); else passed++;
        checks++; if (read_data_mmry_o !== 32'h0) $display("FAIL rst_rdata got %h exp 0", read_data_mmry_o); else passed++;
        checks++; if (misaligned_o !== 1'b0) $display("FAIL rst_mis got %b exp 0", misaligned_o); else passed++;
        checks++; if (bus_error_o !== 1'b0) $display("FAIL rst_err got %b exp 0", bus_error_o); else passed++;
        checks++; if (bus_if.bus_we_o !== 1'b0) $display("FAIL rst_we got %b exp 0", bus_if.bus_we_o); else passed++;
        checks++; if (bus_if.bus_byte_en_o !== 4'h0) $display("FAIL rst_be got %h exp 0", bus_if.bus_byte_en_o); else passed++;
        checks++; if (bus_if.bus_addr_o !== 32'h0) $display("FAIL rst_addr got %h exp 0", bus_if.bus_addr_o); else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF);
        checks++; if (o_stall !== 4) $display("FAIL lw_stall_cycles got %0d exp 4", o_stall); else passed++;
        checks++; if (o_req !== 3) $display("FAIL lw_req_cycles got %0d exp 3", o_req); else passed++;
        checks++; if (o_addr0 !== 32'h10) $display("FAIL lw_addr got %h exp 00000010", o_addr0); else passed++;
        checks++; if (o_addr_last !== 32'h10) $display("FAIL lw_addr_latched got %h exp 00000010", o_addr_last); else passed++;
        checks++; if (o_be !== 4'b1111) $display("FAIL lw_be got %b exp 1111", o_be); else passed++;
        checks++; if (o_we !== 1'b0) $display("FAIL lw_we got %b exp 0", o_we); else passed++;
        checks++; if (o_data !== 32'hDEADBEEF) $display("FAIL lw_data got %h exp deadbeef", o_data); else passed++;
        checks++; if (o_err !== 1'b0) $display("FAIL lw_err got %b exp 0", o_err); else passed++;
        checks++; if (o_done_stall !== 1'b0) $display("FAIL lw_done_stall got %b exp 0", o_done_stall); else passed++;
        checks++; if (o_done_req !== 1'b0) $display("FAIL lw_done_req got %b exp 0", o_done_req); else passed++;
        checks++; if (o_data_after !== 32'hDEADBEEF) $display("FAIL lw_data_hold got %h exp deadbeef", o_data_after); else passed++;
        checks++; if (o_stall_after !== 1'b0) $display("FAIL lw_no_reissue got %b exp 0", o_stall_after); else passed++;
    endtask

    task automatic test_ack_ignored();
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'h12345678;
        #1;
        checks++; if (bus_if.bus_req_o !== 1'b0) $display("FAIL idle_ack_req got %b exp 0", bus_if.bus_req_o); else passed++;
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        checks++; if (read_data_mmry_o !== 32'hDEADBEEF) $display("FAIL idle_ack_data got %h exp deadbeef", read_data_mmry_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL idle_ack_stall got %b exp 0", stall_o); else passed++;
        tick();
    endtask

    task automatic test_byte_half_loads();
        access(1, 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h80112233);
        checks++; if (o_data !== 32'hFFFFFF80) $display("FAIL lb_data got %h exp ffffff80", o_data); else passed++;
        checks++; if (o_be !== 4'b1000) $display("FAIL lb_be got %b exp 1000", o_be); else passed++;
        checks++; if (o_addr0 !== 32'h10) $display("FAIL lb_addr got %h exp 00000010", o_addr0); else passed++;
        checks++; if (o_stall !== 2) $display("FAIL lb_stall_cycles got %0d exp 2", o_stall); else passed++;
        access(1, 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'h80112233);
        checks++; if (o_data !== 32'h00000080) $display("FAIL lbu_data got %h exp 00000080", o_data); else passed++;
        access(1, 0, 2'b01, 0, 32'h02, 32'h0, 1, 32'h80112233);
        checks++; if (o_data !== 32'hFFFF8011) $display("FAIL lh_data got %h exp ffff8011", o_data); else passed++;
        checks++; if (o_be !== 4'b1100) $display("FAIL lh_be got %b exp 1100", o_be); else passed++;
        access(1, 0, 2'b01, 1, 32'h00, 32'h0, 0, 32'h1234F678);
        checks++; if (o_data !== 32'h0000F678) $display("FAIL lhu_data got %h exp 0000f678", o_data); else passed++;
        checks++; if (o_be !== 4'b0011) $display("FAIL lhu_be got %b exp 0011", o_be); else passed++;
    endtask

    task automatic test_stores();
        access(0, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 0, 32'h0);
        checks++; if (o_we !== 1'b1) $display("FAIL sh_we got %b exp 1", o_we); else passed++;
        checks++; if (o_be !== 4'b1100) $display("FAIL sh_be got %b exp 1100", o_be); else passed++;
        checks++; if (o_wd !== 32'hABCDABCD) $display("FAIL sh_wdata got %h exp abcdabcd", o_wd); else passed++;
        checks++; if (o_addr0 !== 32'h20) $display("FAIL sh_addr got %h exp 00000020", o_addr0); else passed++;
        checks++; if (o_stall !== 2) $display("FAIL sh_stall_cycles got %0d exp 2", o_stall); else passed++;
        // read and write together: the write wins
        access(1, 1, 2'b00, 0, 32'h01, 32'h1234565A, 0, 32'h0);
        checks++; if (o_we !== 1'b1) $display("FAIL sb_prio_we got %b exp 1", o_we); else passed++;
        checks++; if (o_be !== 4'b0010) $display("FAIL sb_be got %b exp 0010", o_be); else passed++;
        checks++; if (o_wd !== 32'h5A5A5A5A) $display("FAIL sb_wdata got %h exp 5a5a5a5a", o_wd); else passed++;
        access(0, 1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 1, 32'h0);
        checks++; if (o_wd !== 32'hCAFEF00D) $display("FAIL sw_wdata got %h exp cafef00d", o_wd); else passed++;
        checks++; if (o_addr_last !== 32'h7C) $display("FAIL sw_top_addr got %h exp 0000007c", o_addr_last); else passed++;
        checks++; if (o_mis !== 1'b0) $display("FAIL sw_top_mis got %b exp 0", o_mis); else passed++;
    endtask

    task automatic test_misaligned();
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11223344);
        checks++; if (o_data !== 32'h11223344) $display("FAIL pre_fault_data got %h exp 11223344", o_data); else passed++;
        access(1, 0, 2'b10, 0, 32'h06, 32'h0, 0, 32'h0);
        checks++; if (o_mis !== 1'b1) $display("FAIL lw06_mis got %b exp 1", o_mis); else passed++;
        checks++; if (o_stall !== 0) $display("FAIL lw06_stall got %0d exp 0", o_stall); else passed++;
        checks++; if (o_req_fault !== 1'b0) $display("FAIL lw06_req got %b exp 0", o_req_fault); else passed++;
        checks++; if (o_req_after !== 1'b0) $display("FAIL lw06_req_after got %b exp 0", o_req_after); else passed++;
        checks++; if (o_fault_rd !== 32'h0) $display("FAIL lw06_rdata got %h exp 0", o_fault_rd); else passed++;
        checks++; if (o_mis_after !== 1'b0) $display("FAIL lw06_pulse got %b exp 0", o_mis_after); else passed++;
        checks++; if (o_data_after !== 32'h0) $display("FAIL lw06_rdata_hold got %h exp 0", o_data_after); else passed++;
        access(1, 0, 2'b10, 0, 32'h80, 32'h0, 0, 32'h0);
        checks++; if (o_mis !== 1'b1) $display("FAIL lw80_mis got %b exp 1", o_mis); else passed++;
        checks++; if (o_stall !== 0) $display("FAIL lw80_stall got %0d exp 0", o_stall); else passed++;
        access(1, 0, 2'b01, 0, 32'h05, 32'h0, 0, 32'h0);
        checks++; if (o_mis !== 1'b1) $display("FAIL lh05_mis got %b exp 1", o_mis); else passed++;
        access(1, 0, 2'b11, 0, 32'h0C, 32'h0, 0, 32'h77665544);
        checks++; if (o_data !== 32'h77665544) $display("FAIL rsvd_word_data got %h exp 77665544", o_data); else passed++;
    endtask

    task automatic test_timeout();
        // ack on the fourth (last permitted) cycle wins over the timeout
        access(1, 0, 2'b10, 0, 32'h08, 32'h0, 3, 32'h0BADF00D);
        checks++; if (o_req !== 4) $display("FAIL ack_at_limit_req got %0d exp 4", o_req); else passed++;
        checks++; if (o_err !== 1'b0) $display("FAIL ack_at_limit_err got %b exp 0", o_err); else passed++;
        checks++; if (o_data !== 32'h0BADF00D) $display("FAIL ack_at_limit_data got %h exp 0badf00d", o_data); else passed++;
        access(1, 0, 2'b10, 0, 32'h04, 32'h0, -1, 32'h0);
        checks++; if (o_req !== 4) $display("FAIL to_req_cycles got %0d exp 4", o_req); else passed++;
        checks++; if (o_stall !== 5) $display("FAIL to_stall_cycles got %0d exp 5", o_stall); else passed++;
        checks++; if (o_err !== 1'b1) $display("FAIL to_err got %b exp 1", o_err); else passed++;
        checks++; if (o_data !== 32'h0) $display("FAIL to_data got %h exp 0", o_data); else passed++;
        checks++; if (o_err_after !== 1'b0) $display("FAIL to_err_pulse got %b exp 0", o_err_after); else passed++;
    endtask

    task automatic test_reset_mid_access();
        access(1, 0, 2'b10, 0, 32'h14, 32'h0, 0, 32'hA5A5A5A5);
        mem_read_i = 1; mem_size_i = 2'b10; address_i = 32'h40;
        tick();
        checks++; if (bus_if.bus_req_o !== 1'b1) $display("FAIL mid_req_before got %b exp 1", bus_if.bus_req_o); else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus_if.bus_req_o !== 1'b0) $display("FAIL mid_req_async got %b exp 0", bus_if.bus_req_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL mid_stall_async got %b exp 0", stall_o); else passed++;
        checks++; if (read_data_mmry_o !== 32'h0) $display("FAIL mid_rdata_rst got %h exp 0", read_data_mmry_o); else passed++;
        clear_inputs();
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hFFFFFFFF;
        tick();
        reset = 1'b1;
        bus_if.bus_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_if.bus_req_o !== 1'b0 || stall_o !== 1'b0 || bus_error_o !== 1'b0 || read_data_mmry_o !== 32'h0)
                $display("FAIL post_rst_idle cycle %0d got req=%b stall=%b err=%b rdata=%h exp all 0",
                         i, bus_if.bus_req_o, stall_o, bus_error_o, read_data_mmry_o);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_ack_ignored();
        test_byte_half_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access engine between the EX/MEM and MEM/WB pipeline registers.
- Turns load/store control from EX/MEM into a handshaked, multi-cycle data-bus transaction.
- Stalls the pipeline until the bus acknowledges, then sign/zero-extends load data into read_data_mmry_o, which feeds MEM/WB read_data_mmry_i.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS-state cycles without bus_ack_i before the access is aborted.
- MEMORY_DEPTH, 32: data memory size in words. Addresses at or above MEMORY_DEPTH*4 are out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read_i  in  1  load request from EX/MEM.
- mem_write_i  in  1  store request from EX/MEM.
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned_i  in  1  load extension: 1 zero-extend (lbu/lhu), 0 sign-extend.
- address_i  in  32  byte address (the ALU result).
- write_data_i  in  32  store data, right-justified.
- bus_req_o  out  1  bus request, held until ack.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word address: address_i with bits [1:0] forced to 0.
- bus_byte_en_o  out  4  byte-lane enables.
- bus_wdata_o  out  32  store data replicated/shifted onto the lanes.
- bus_ack_i  in  1  one-cycle acknowledge; bus_rdata_i is valid in the same cycle.
- bus_rdata_i  in  32  read word.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- read_data_mmry_o  out  32  extended load result.
- misaligned_o  out  1  one-cycle alignment/range fault pulse.
- bus_error_o  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0, including read_data_mmry_o = 0.
- Request: req = mem_read_i | mem_write_i. If both are set, the write takes priority.
- Lane mapping is little-endian; lane = address_i[1:0].
  - Byte: enable 1<<lane; data = {4{wd[7:0]}}.
  - Half: enable 0011 or 1100; data = {2{wd[15:0]}}.
  - Word: enable 1111.
- Fault condition (checked in IDLE):
  - half with address_i[0]=1, or
  - word with address_i[1:0]!=0, or
  - address >= MEMORY_DEPTH*4.
  - On fault: no bus request, misaligned_o=1 for that cycle, stall_o=0, read_data_mmry_o=0. The instruction proceeds.
- States:
  - IDLE: if req and no fault, stall_o=1 combinationally and go to ACCESS. Address, we, enables and wdata are latched at that edge.
  - ACCESS: bus_req_o=1 with latched fields stable; stall_o=1. The counter increments each cycle.
    - On bus_ack_i: capture bus_rdata_i, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES first: go to DONE, set bus_error_o for the DONE cycle, captured data = 0.
  - DONE: stall_o=0, bus_req_o=0, read_data_mmry_o valid. EX/MEM and MEM/WB advance at the end of this cycle. Next state is IDLE unconditionally, so the same instruction is never reissued.
- Load extension: select the byte/half by latched lane, then sign- or zero-extend. Word is passed through. read_data_mmry_o holds its value until the next DONE or fault cycle.
- Latency: ack arriving k cycles after entry into ACCESS (k>=0) gives data in DONE at entry+k+1. The minimum load costs 2 stall cycles (IDLE-detect, ACCESS).
- Boundary conditions:
  - bus_ack_i is ignored outside ACCESS.
  - An ack in the same cycle the counter hits the limit counts as success (ack wins).
  - Inputs changing during ACCESS are ignored, because the fields are latched.
  - Reset asserted mid-ACCESS drops bus_req_o immediately (asynchronously) and discards the transaction.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Shared package holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encoding IDLE/ACCESS/DONE;
  - the lane-enable function.
- One natural sub-module: load_extender (combinational lane select plus sign/zero extension). It is reusable by the write-back mux.

Test Plan:
- Word load, addr 0x10, ack after 2 ACCESS cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles, DONE read_data_mmry_o=0xDEADBEEF, bus_addr_o=0x10, byte_en=1111.
- lb addr 0x13 signed, rdata 0x80112233 -> read_data_mmry_o=0xFFFFFF80; lbu same -> 0x00000080.
- sh addr 0x22, write_data 0x0000ABCD, immediate ack -> bus_we_o=1, byte_en=1100, bus_wdata_o=0xABCDABCD, addr 0x20.
- lw addr 0x06 -> misaligned_o pulse, bus_req_o never rises, stall_o=0; address 0x80 with MEMORY_DEPTH=32 -> same fault.
- Load with no ack, TIMEOUT_CYCLES=4 -> bus_req_o high 4 cycles, bus_error_o pulse in DONE, read_data_mmry_o=0; ack arriving on cycle 4 -> no error, data captured.
- reset driven low mid-ACCESS -> bus_req_o and stall_o go 0 asynchronously; after release, state is IDLE and no stale DONE cycle occurs.
